// File: rtl/ahb_slave_bus_adapter.sv
// AHB-Lite slave front end: turns AHB address/data phases into memory-side write/read strobes.
// The memory behind it returns DOUT one cycle after RD.
module ahb_slave_bus_adapter #(
   parameter int ADDR_BITS = 24,
   parameter int DATA_BITS = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   HSEL,
   input  logic [31:0]            HADDR,
   input  logic [1:0]             HTRANS,
   input  logic                   HWRITE,
   input  logic [2:0]             HSIZE,
   input  logic [2:0]             HBURST,
   input  logic [DATA_BITS-1:0]   HWDATA,
   input  logic                   HREADY,
   output logic                   HREADYOUT,
   output logic                   HRESP,
   output logic [DATA_BITS-1:0]   HRDATA,
   output logic                   WR,
   output logic [ADDR_BITS-1:0]   ADDR_WR,
   output logic [DATA_BITS-1:0]   DIN,
   output logic [DATA_BITS/8-1:0] BSEL,
   output logic                   RD,
   output logic [ADDR_BITS-1:0]   ADDR_RD,
   input  logic [DATA_BITS-1:0]   DOUT
);
   localparam int NB = DATA_BITS / 8;
   localparam int LB = $clog2(NB);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WDATA  = 3'd1,
      S_RDATA  = 3'd2,
      S_RDEFER = 3'd3,
      S_ERR1   = 3'd4,
      S_ERR2   = 3'd5
   } state_t;

   state_t               state;
   logic [ADDR_BITS-1:0] a_addr;
   logic [2:0]           a_size;
   logic                 a_write;
   logic                 accepting;
   logic                 take;
   logic                 err;
   logic                 rd_issue;
   logic                 wr_active;
   logic                 unused_ok;

   // Low address bits that must be zero for a naturally aligned transfer of this size.
   function automatic logic [LB-1:0] size_mask(input logic [2:0] size);
      logic [LB-1:0] m;
      for (int i = 0; i < LB; i++) begin
         m[i] = (i < int'(size));
      end
      return m;
   endfunction

   function automatic logic [NB-1:0] lane_sel(input logic [2:0] size, input logic [LB-1:0] off);
      logic [NB-1:0] m;
      int            lo;
      int            n;
      lo = int'(off);
      n  = 32'd1 << size;
      for (int i = 0; i < NB; i++) begin
         m[i] = (i >= lo) && (i < lo + n);
      end
      return m;
   endfunction

   // ERR1 and RDEFER hold HREADY low, so only these states can see a new address phase.
   assign accepting = (state == S_IDLE) || (state == S_WDATA) || (state == S_RDATA) || (state == S_ERR2);
   assign take      = HSEL && HTRANS[1] && HREADY && accepting;
   assign err       = take && ((HSIZE > 3'(LB)) || ((HADDR[LB-1:0] & size_mask(HSIZE)) != '0));
   assign rd_issue  = take && !HWRITE && !err && (state != S_WDATA) && !reset;
   assign wr_active = (state == S_WDATA) && a_write;
   assign unused_ok = &{1'b0, HBURST, HADDR[31:ADDR_BITS]};

   // Transfer FSM and address-phase capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         a_addr  <= '0;
         a_size  <= 3'd0;
         a_write <= 1'b0;
      end else begin
         if (take) begin
            a_addr  <= HADDR[ADDR_BITS-1:0];
            a_size  <= HSIZE;
            a_write <= HWRITE;
         end
         case (state)
            S_IDLE, S_WDATA, S_RDATA, S_ERR2: begin
               if (!take)                 state <= S_IDLE;
               else if (err)              state <= S_ERR1;
               else if (HWRITE)           state <= S_WDATA;
               else if (state == S_WDATA) state <= S_RDEFER;
               else                       state <= S_RDATA;
            end
            S_RDEFER: state <= S_RDATA;
            S_ERR1:   state <= S_ERR2;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Strobe and response decode; a read behind a write is replayed from a_addr in RDEFER.
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = '0;
      WR        = 1'b0;
      ADDR_WR   = '0;
      DIN       = '0;
      BSEL      = '0;
      RD        = 1'b0;
      ADDR_RD   = '0;
      if (wr_active) begin
         WR      = 1'b1;
         ADDR_WR = a_addr;
         DIN     = HWDATA;
         BSEL    = lane_sel(a_size, a_addr[LB-1:0]);
      end else begin
         WR = 1'b0;
      end
      if (state == S_RDEFER) begin
         RD        = 1'b1;
         ADDR_RD   = a_addr;
         HREADYOUT = 1'b0;
      end else if (rd_issue) begin
         RD      = 1'b1;
         ADDR_RD = HADDR[ADDR_BITS-1:0];
      end else begin
         RD = 1'b0;
      end
      if (state == S_RDATA) begin
         HRDATA = DOUT;
      end else begin
         HRDATA = '0;
      end
      if (state == S_ERR1) begin
         HRESP     = 1'b1;
         HREADYOUT = 1'b0;
      end else if (state == S_ERR2) begin
         HRESP = 1'b1;
      end else begin
         HRESP = 1'b0;
      end
   end
endmodule
